// File: rtl/pll_lock_reset_seq.sv
// pll_lock_reset_seq: reset sequencer on the consumer side of the PLL clock wrapper.
// Holds sys_rst until the synchronised PLL lock has been stable long enough,
// then releases it and produces a periodic clock-enable tick while running.
// A loss of lock while running re-enters reset and is recorded in lost_flag.
// Optional macro LOCK_LOSS_CNT_EN adds a saturating lock-loss event counter on
// lost_cnt; without it lost_cnt is tied to zero.

module pll_lock_reset_seq #(
   parameter int HOLD_CYCLES   = 16,
   parameter int STABLE_CYCLES = 1200,
   parameter int TICK_DIV      = 12
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       pll_lock,
   input  logic       clr_lost,
   output logic       sys_rst,
   output logic       ready,
   output logic       tick,
   output logic       lost_flag,
   output logic [7:0] lost_cnt
);

   localparam int MAX_CYC = (HOLD_CYCLES > STABLE_CYCLES) ? HOLD_CYCLES : STABLE_CYCLES;
   localparam int CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
   localparam int DW      = $clog2(TICK_DIV);

   localparam logic [CW-1:0] HOLD_LAST   = CW'(HOLD_CYCLES - 1);
   localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_CYCLES - 1);
   localparam logic [DW-1:0] DIV_LAST    = DW'(TICK_DIV - 1);

   typedef enum logic [1:0] {
      ST_HOLD,
      ST_WAIT_LOCK,
      ST_STABLE,
      ST_RUN
   } state_t;

   state_t          state_q;
   state_t          state_d;
   logic [1:0]      sync_q;
   logic            lock_s;
   logic [CW-1:0]   cnt_q;
   logic [DW-1:0]   div_q;
   logic            sys_rst_d;
   logic            ready_d;
   logic            run_stay;
   logic            lost_set;

   assign lock_s = sync_q[1];

   // Two-flop synchroniser: raw pll_lock is asynchronous to clk
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q <= 2'b00;
      end else begin
         sync_q <= {sync_q[0], pll_lock};
      end
   end

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_HOLD;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; any dip of lock_s before the stable count completes restarts it
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_HOLD: begin
            if (cnt_q == HOLD_LAST) begin
               state_d = ST_WAIT_LOCK;
            end
         end
         ST_WAIT_LOCK: begin
            if (lock_s) begin
               state_d = ST_STABLE;
            end
         end
         ST_STABLE: begin
            if (!lock_s) begin
               state_d = ST_WAIT_LOCK;
            end else if (cnt_q == STABLE_LAST) begin
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            if (!lock_s) begin
               state_d = ST_HOLD;
            end
         end
         default: state_d = ST_HOLD;
      endcase
   end

   // Output decode from the next state so the registered outputs switch on the transition edge
   always_comb begin
      sys_rst_d = 1'b1;
      ready_d   = 1'b0;
      run_stay  = 1'b0;
      lost_set  = 1'b0;
      if (state_d == ST_RUN) begin
         sys_rst_d = 1'b0;
         ready_d   = 1'b1;
      end
      if (state_q == ST_RUN && state_d == ST_RUN) begin
         run_stay = 1'b1;
      end
      if (state_q == ST_RUN && state_d == ST_HOLD) begin
         lost_set = 1'b1;
      end
   end

   // Shared HOLD/STABLE counter, cleared whenever the state changes
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else if (state_d != state_q) begin
         cnt_q <= '0;
      end else if (state_q == ST_HOLD || (state_q == ST_STABLE && lock_s)) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   // Registered sys_rst and ready
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sys_rst <= 1'b1;
         ready   <= 1'b0;
      end else begin
         sys_rst <= sys_rst_d;
         ready   <= ready_d;
      end
   end

   // Tick divider runs only while staying in RUN; entering or leaving RUN clears it
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_q <= '0;
         tick  <= 1'b0;
      end else if (run_stay) begin
         if (div_q == DIV_LAST) begin
            div_q <= '0;
            tick  <= 1'b1;
         end else begin
            div_q <= div_q + 1'b1;
            tick  <= 1'b0;
         end
      end else begin
         div_q <= '0;
         tick  <= 1'b0;
      end
   end

   // Sticky lock-loss flag; a new loss beats a simultaneous clear
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lost_flag <= 1'b0;
      end else if (lost_set) begin
         lost_flag <= 1'b1;
      end else if (clr_lost) begin
         lost_flag <= 1'b0;
      end
   end

`ifdef LOCK_LOSS_CNT_EN
   // Saturating loss counter; a loss in the same cycle as a clear leaves a count of one
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lost_cnt <= 8'd0;
      end else if (lost_set) begin
         if (clr_lost) begin
            lost_cnt <= 8'd1;
         end else if (lost_cnt != 8'hFF) begin
            lost_cnt <= lost_cnt + 8'd1;
         end
      end else if (clr_lost) begin
         lost_cnt <= 8'd0;
      end
   end
`else
   assign lost_cnt = 8'd0;
`endif

endmodule
